// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer.
package word_serializer_pkg;

  // Default serial word length in bits.
  localparam int WIDTH_DEFAULT = 8;

  // IDLE: shifter empty. SHIFT: shifter holds a word being emitted.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_hold_buf.sv
// One-entry hold buffer: parks the next word while the current one shifts out.
module word_hold_buf
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  logic [WIDTH-1:0] data_q;

  // Occupancy flag: set on write, cleared on read or reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    if (reset) begin
      full <= 1'b0;
    end else if (wr_en) begin
      full <= 1'b1;
    end else if (rd_en) begin
      full <= 1'b0;
    end
  end

  // Payload register, only meaningful while full is set.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; the full flag qualifies it.
    if (wr_en) begin
      data_q <= wr_data;
    end
  end

  assign rd_data = data_q;

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter, MSB first, with ready/valid on both sides and
// a one-entry hold buffer so back-to-back words stream without bubbles.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  input  logic             out_ready
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] count;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_wr;
  logic             hold_rd;

  logic             in_xfer;
  logic             out_xfer;
  logic             last_xfer;

  assign in_ready  = !hold_full && !reset;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = (state == SHIFT) && out_ready;
  assign last_xfer = out_xfer && (count == LAST_CNT);

  // A word arriving mid-shift parks in the hold buffer; in the last-bit cycle
  // with the buffer empty it bypasses straight into the shifter instead.
  assign hold_wr = in_xfer && (state == SHIFT) && !last_xfer;
  assign hold_rd = last_xfer && hold_full;

  word_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hold_wr),
    .wr_data (in_data),
    .rd_en   (hold_rd),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  // FSM, shifter and bit counter advance together on input/output transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      shifter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            shifter <= in_data;
            count   <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            count <= '0;
            if (hold_full) begin
              shifter <= hold_data;
            end else if (in_xfer) begin
              shifter <= in_data;
            end else begin
              shifter <= '0;
              state   <= IDLE;
            end
          end else if (out_xfer) begin
            shifter <= {shifter[WIDTH-2:0], 1'b0};
            count   <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so in_data never reaches sout.
  assign sout       = shifter[WIDTH-1];
  assign sout_valid = (state == SHIFT);
  assign sout_first = (state == SHIFT) && (count == '0);
  assign sout_last  = (state == SHIFT) && (count == LAST_CNT);

endmodule
